md_sequencer: RTL and testbench

- Iterative multiply/divide unit and its controller, sitting behind the MUL and DIV reservation-station entries.
- Accepts one request with the decoder's md request fields (op, operand signedness, output select) plus operands and a tag.
- Runs a radix-2 shift-add / restoring-divide sequence and presents the 32-bit result with its tag to the writeback/CDB arbiter.
- One operation in flight at a time.

---
 rtl/md_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_md_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide unit with its own controller.
//
// Takes one MUL/DIV/REM request at a time, runs a radix-2 shift-add
// multiply or restoring divide over XPR_LEN iterations, applies the sign
// fixup, and holds the result with its tag until the writeback side takes it.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_*               request handshake, op fields, operands, tag
//   kill                squash whatever is in flight (flush)
//   resp_*              result handshake, result and tag
//
// Build option:
//   MD_EARLY_OUT_EN     when defined, zero-operand MUL and zero-dividend or
//                       zero-divisor DIV/REM skip the iteration phase.
module md_sequencer #(
    parameter int XPR_LEN   = 32,
    parameter int TAG_WIDTH = 4,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic                 req_in_1_signed,
    input  logic                 req_in_2_signed,
    input  logic [1:0]           req_out_sel,
    input  logic [XPR_LEN-1:0]   req_in_1,
    input  logic [XPR_LEN-1:0]   req_in_2,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 kill,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [XPR_LEN-1:0]   resp_result,
    output logic [TAG_WIDTH-1:0] resp_tag
);

    localparam logic [1:0] OP_DIV  = 2'd1;
    localparam logic [1:0] OP_REM  = 2'd2;
    localparam logic [1:0] SEL_HI  = 2'd1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(XPR_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_COMPUTE,
        S_FIXUP,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0]           op;
        logic                 in_1_signed;
        logic                 in_2_signed;
        logic [1:0]           out_sel;
        logic [XPR_LEN-1:0]   in_1;
        logic [XPR_LEN-1:0]   in_2;
        logic [TAG_WIDTH-1:0] tag;
    } md_req_t;

    state_t                 state, state_nxt;
    md_req_t                req_q;
    logic [2*XPR_LEN-1:0]   acc;
    logic [XPR_LEN-1:0]     opnd;       // multiplicand (MUL) or divisor magnitude (DIV/REM)
    logic                   neg_res;    // operand signs differ
    logic                   neg_rem;    // dividend was negative
    logic [CNT_WIDTH-1:0]   cnt;

    // ---------------- request decode / magnitudes ----------------
    logic                   is_mul;
    logic                   neg_1, neg_2;
    logic [XPR_LEN-1:0]     abs_1, abs_2;
    logic                   early_out;

    // op 3 decodes as MUL
    assign is_mul = (req_q.op != OP_DIV) && (req_q.op != OP_REM);
    assign neg_1  = req_q.in_1_signed & req_q.in_1[XPR_LEN-1];
    assign neg_2  = req_q.in_2_signed & req_q.in_2[XPR_LEN-1];
    assign abs_1  = neg_1 ? -req_q.in_1 : req_q.in_1;
    assign abs_2  = neg_2 ? -req_q.in_2 : req_q.in_2;

`ifdef MD_EARLY_OUT_EN
    // A cleared accumulator already is the correct product / quotient /
    // remainder for these cases; divide-by-zero is patched up in FIXUP.
    assign early_out = is_mul ? ((abs_1 == '0) || (abs_2 == '0))
                              : ((abs_1 == '0) || (abs_2 == '0));
`else
    assign early_out = 1'b0;
`endif

    // ---------------- one iteration step ----------------
    // acc = {hi, lo}. MUL: lo starts as the multiplier and is consumed from
    // the bottom while the product grows into hi. DIV: lo starts as the
    // dividend and fills with quotient bits, hi holds the partial remainder.
    logic [XPR_LEN:0]       mul_sum;
    logic [2*XPR_LEN-1:0]   mul_next;
    logic [XPR_LEN:0]       rem_sh;
    logic                   div_ge;
    logic [XPR_LEN-1:0]     div_sub;
    logic [2*XPR_LEN-1:0]   div_next;

    assign mul_sum  = {1'b0, acc[2*XPR_LEN-1:XPR_LEN]}
                    + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[XPR_LEN-1:1]};

    // Shifted remainder is XPR_LEN+1 bits; a successful trial subtract
    // always leaves a value below the divisor, so XPR_LEN bits suffice.
    assign rem_sh   = acc[2*XPR_LEN-1:XPR_LEN-1];
    assign div_ge   = rem_sh >= {1'b0, opnd};
    assign div_sub  = rem_sh[XPR_LEN-1:0] - opnd;
    assign div_next = div_ge ? {div_sub,             acc[XPR_LEN-2:0], 1'b1}
                             : {rem_sh[XPR_LEN-1:0], acc[XPR_LEN-2:0], 1'b0};

    // ---------------- sign fixup / result select ----------------
    logic [2*XPR_LEN-1:0]   prod;
    logic [XPR_LEN-1:0]     quot, rem, quot_fix, rem_fix;
    logic                   div_zero;
    logic [XPR_LEN-1:0]     result;

    // Signed overflow (most-negative / -1) needs no special case: the
    // magnitude quotient 2^(XPR_LEN-1) negates back onto itself, remainder 0.
    assign prod     = neg_res ? -acc : acc;
    assign quot     = acc[XPR_LEN-1:0];
    assign rem      = acc[2*XPR_LEN-1:XPR_LEN];
    assign div_zero = (opnd == '0);
    assign quot_fix = div_zero ? '1         : (neg_res ? -quot : quot);
    assign rem_fix  = div_zero ? req_q.in_1 : (neg_rem ? -rem  : rem);

    always_comb begin
        result = quot_fix;
        if (is_mul)
            result = (req_q.out_sel == SEL_HI) ? prod[2*XPR_LEN-1:XPR_LEN]
                                                : prod[XPR_LEN-1:0];
        else if (req_q.op == OP_REM)
            result = rem_fix;
    end

    // ---------------- control ----------------
    assign req_ready  = !reset && (state == S_IDLE) && !kill;
    assign resp_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (req_valid && req_ready) state_nxt = S_SETUP;
            S_SETUP:   state_nxt = early_out ? S_FIXUP : S_COMPUTE;
            S_COMPUTE: if (cnt == CNT_LAST) state_nxt = S_FIXUP;
            S_FIXUP:   state_nxt = S_DONE;
            S_DONE:    if (resp_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (kill)
            state_nxt = S_IDLE;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q       <= '0;
            acc         <= '0;
            opnd        <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            cnt         <= '0;
            resp_result <= '0;
            resp_tag    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready)
                        req_q <= '{op: req_op, in_1_signed: req_in_1_signed,
                                   in_2_signed: req_in_2_signed,
                                   out_sel: req_out_sel, in_1: req_in_1,
                                   in_2: req_in_2, tag: req_tag};
                end
                S_SETUP: begin
                    acc     <= early_out ? '0
                             : {{XPR_LEN{1'b0}}, (is_mul ? abs_2 : abs_1)};
                    opnd    <= is_mul ? abs_1 : abs_2;
                    neg_res <= neg_1 ^ neg_2;
                    neg_rem <= neg_1;
                    cnt     <= '0;
                end
                S_COMPUTE: begin
                    acc <= is_mul ? mul_next : div_next;
                    cnt <= cnt + 1'b1;
                end
                S_FIXUP: begin
                    resp_result <= result;
                    resp_tag    <= req_q.tag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: hand-computed results, latency,
// backpressure, kill and reset behaviour.
module tb_md_sequencer;

    localparam logic [1:0] MUL = 2'd0, DIV = 2'd1, REM = 2'd2;
    localparam logic [1:0] LO = 2'd0, HI = 2'd1, RS = 2'd2;
`ifdef MD_EARLY_OUT_EN
    localparam int LAT_Z = 3;
`else
    localparam int LAT_Z = 35;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [1:0]  req_op, req_out_sel;
    logic        req_in_1_signed, req_in_2_signed;
    logic [31:0] req_in_1, req_in_2;
    logic [3:0]  req_tag;
    logic        kill;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_result;
    logic [3:0]  resp_tag;

    int n_vec = 0;
    int n_err = 0;

    md_sequencer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_in_1_signed(req_in_1_signed),
        .req_in_2_signed(req_in_2_signed), .req_out_sel(req_out_sel),
        .req_in_1(req_in_1), .req_in_2(req_in_2), .req_tag(req_tag),
        .kill(kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns 1ns after the accepting posedge.
    task automatic issue(input logic [1:0] op, input logic s1, input logic s2,
                         input logic [1:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
        int w;
        req_op = op; req_in_1_signed = s1; req_in_2_signed = s2;
        req_out_sel = sel; req_in_1 = a; req_in_2 = b; req_tag = tag;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Cycles from accept until resp_valid is seen (bounded).
    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!resp_valid && cyc < 100);
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic s1,
                       input logic s2, input logic [1:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag,
                       input logic [31:0] exp, input int lat);
        int c;
        @(negedge clk);
        issue(op, s1, s2, sel, a, b, tag);
        wait_valid(c);
        chk({name, "_lat"}, c, lat);
        chk({name, "_res"}, resp_result, exp);
        chk({name, "_tag"}, {28'd0, resp_tag}, {28'd0, tag});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        reset = 1'b1; req_valid = 1'b0; kill = 1'b0; resp_ready = 1'b1;
        req_op = MUL; req_in_1_signed = 1'b0; req_in_2_signed = 1'b0;
        req_out_sel = LO; req_in_1 = '0; req_in_2 = '0; req_tag = '0;

        // reset state
        repeat (3) @(negedge clk);
        req_valid = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_tag", {28'd0, resp_tag}, 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // arithmetic vectors
        run("mul_lo_uu",  MUL, 0, 0, LO, 32'd7,        32'hFFFFFFFD, 4'h1, 32'hFFFFFFEB, 35);
        run("mulh_ss",    MUL, 1, 1, HI, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h2, 32'h00000000, 35);
        run("mulhu",      MUL, 0, 0, HI, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h3, 32'hFFFFFFFE, 35);
        run("mulhsu",     MUL, 1, 0, HI, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h4, 32'hFFFFFFFF, 35);
        run("mul_lo_ss",  MUL, 1, 1, LO, 32'hFFFFFFFD, 32'd5,        4'hC, 32'hFFFFFFF1, 35);
        run("div_s",      DIV, 1, 1, LO, 32'hFFFFFFF9, 32'd2,        4'h5, 32'hFFFFFFFD, 35);
        run("rem_s",      REM, 1, 1, RS, 32'hFFFFFFF9, 32'd2,        4'h6, 32'hFFFFFFFF, 35);
        run("divu",       DIV, 0, 0, LO, 32'hFFFFFFF9, 32'd2,        4'h7, 32'h7FFFFFFC, 35);
        run("remu",       REM, 0, 0, RS, 32'd100,      32'd7,        4'hD, 32'd2,        35);
        run("div_ovf",    DIV, 1, 1, LO, 32'h80000000, 32'hFFFFFFFF, 4'h8, 32'h80000000, 35);
        run("rem_ovf",    REM, 1, 1, RS, 32'h80000000, 32'hFFFFFFFF, 4'h9, 32'h00000000, 35);
        run("div_z",      DIV, 1, 1, LO, 32'd5,        32'd0,        4'hA, 32'hFFFFFFFF, LAT_Z);
        run("rem_z",      REM, 1, 1, RS, 32'd5,        32'd0,        4'hB, 32'd5,        LAT_Z);
        run("rem_z_neg",  REM, 1, 1, RS, 32'hFFFFFFF9, 32'd0,        4'hE, 32'hFFFFFFF9, LAT_Z);

        // backpressure: result held, no new accept, then release
        @(negedge clk);
        resp_ready = 1'b0;
        issue(MUL, 0, 0, LO, 32'd3, 32'd5, 4'h9);
        wait_valid(c);
        chk("bp_lat", c, 35);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_res", resp_result, 32'd15);
            chk("bp_tag", {28'd0, resp_tag}, 32'd9);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_drop", {31'd0, resp_valid}, 32'd0);
        chk("bp_idle", {31'd0, req_ready}, 32'd1);

        // kill at cycle 20 of a DIV, then new request the very next cycle
        issue(DIV, 0, 0, LO, 32'd100, 32'd7, 4'h5);
        repeat (20) @(negedge clk);
        kill = 1'b1;
        #1;
        chk("kill_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        kill = 1'b0;
        #1;
        chk("kill_no_valid", {31'd0, resp_valid}, 32'd0);
        issue(DIV, 0, 0, LO, 32'd100, 32'd7, 4'h6);
        wait_valid(c);
        chk("after_kill_lat", c, 35);
        chk("after_kill_res", resp_result, 32'd14);
        chk("after_kill_tag", {28'd0, resp_tag}, 32'd6);

        // kill together with req_valid in IDLE: nothing accepted
        @(negedge clk);
        req_valid = 1'b1; kill = 1'b1;
        #1;
        chk("idle_kill_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_kill_still_idle", {31'd0, req_ready}, 32'd1);
            chk("idle_kill_no_valid", {31'd0, resp_valid}, 32'd0);
        end

        // reset mid-operation clears outputs and returns to idle
        issue(MUL, 0, 0, LO, 32'd9, 32'd9, 4'h3);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_result", resp_result, 32'd0);
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) chk("midrst_spurious_valid", {31'd0, resp_valid}, 32'd0);
        end
        run("post_rst_mul", MUL, 0, 0, LO, 32'd9, 32'd9, 4'h4, 32'd81, 35);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
